// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI3/AXI4 master bus carried between the sram bridge and the interconnect.
// The master modport is the bridge side; the slave modport is the interconnect side.
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data sram-like ports onto one AXI master port.
// One read and one write may be outstanding; every burst is a single beat.
module sram_axi_bridge #(
    parameter logic [3:0] RD_ID_INST = 4'd0,
    parameter logic [3:0] RD_ID_DATA = 4'd1,
    parameter logic [3:0] WR_ID      = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    sram_axi_bridge_if.master axi
);
    typedef enum logic [1:0] {RIdle, RAddr, RData, RResp} rd_state_e;
    typedef enum logic [1:0] {WIdle, WSend, WResp, WDone} wr_state_e;

    rd_state_e   rd_state_q, rd_state_d;
    wr_state_e   wr_state_q, wr_state_d;

    logic        rd_is_data_q;
    logic [31:0] rd_addr_q;
    logic [1:0]  rd_size_q;
    logic [31:0] rdata_q;
    logic [31:0] wr_addr_q;
    logic [1:0]  wr_size_q;
    logic [3:0]  wr_strb_q;
    logic [31:0] wr_data_q;
    logic        aw_done_q, w_done_q;

    logic rd_idle, wr_idle, data_rd_in_flight;
    logic data_rd_acc, data_wr_acc, inst_rd_acc;
    logic aw_hs, w_hs;

    // Holding a single data transaction at a time keeps data_ok in request order.
    always_comb begin
        rd_idle           = (rd_state_q == RIdle);
        wr_idle           = (wr_state_q == WIdle);
        data_rd_in_flight = !rd_idle && rd_is_data_q;
        data_rd_acc       = resetn && rd_idle && wr_idle && data_sram_req && !data_sram_wr;
        data_wr_acc       = resetn && wr_idle && !data_rd_in_flight && !data_rd_acc
                            && data_sram_req && data_sram_wr;
        inst_rd_acc       = resetn && rd_idle && inst_sram_req && !data_rd_acc;
        aw_hs             = (wr_state_q == WSend) && !aw_done_q && axi.awready;
        w_hs              = (wr_state_q == WSend) && !w_done_q && axi.wready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= RIdle;
            wr_state_q <= WIdle;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RIdle: if (data_rd_acc || inst_rd_acc) rd_state_d = RAddr;
            RAddr: if (axi.arready) rd_state_d = RData;
            RData: if (axi.rvalid) rd_state_d = RResp;
            RResp: rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WIdle: if (data_wr_acc) wr_state_d = WSend;
            WSend: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = WResp;
            WResp: if (axi.bvalid) wr_state_d = WDone;
            WDone: wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_is_data_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_size_q    <= '0;
            rdata_q      <= '0;
            wr_addr_q    <= '0;
            wr_size_q    <= '0;
            wr_strb_q    <= '0;
            wr_data_q    <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            if (data_rd_acc || inst_rd_acc) begin
                rd_is_data_q <= data_rd_acc;
                rd_addr_q    <= data_rd_acc ? data_sram_addr : inst_sram_addr;
                rd_size_q    <= data_rd_acc ? data_sram_size : inst_sram_size;
            end
            if (rd_state_q == RData && axi.rvalid) rdata_q <= axi.rdata;
            if (data_wr_acc) begin
                wr_addr_q <= data_sram_addr;
                wr_size_q <= data_sram_size;
                wr_strb_q <= data_sram_wstrb;
                wr_data_q <= data_sram_wdata;
            end
            // Sticky per-channel done flags, cleared once the send phase ends.
            aw_done_q <= (wr_state_d == WSend) && (aw_done_q || aw_hs);
            w_done_q  <= (wr_state_d == WSend) && (w_done_q || w_hs);
        end
    end

    always_comb begin
        inst_sram_addr_ok = inst_rd_acc;
        data_sram_addr_ok = data_rd_acc || data_wr_acc;
        inst_sram_data_ok = (rd_state_q == RResp) && !rd_is_data_q;
        data_sram_data_ok = ((rd_state_q == RResp) && rd_is_data_q) || (wr_state_q == WDone);
        inst_sram_rdata   = rdata_q;
        data_sram_rdata   = rdata_q;

        axi.arid    = rd_is_data_q ? RD_ID_DATA : RD_ID_INST;
        axi.araddr  = rd_addr_q;
        axi.arsize  = {1'b0, rd_size_q};
        axi.arvalid = (rd_state_q == RAddr);
        axi.rready  = (rd_state_q == RData);

        axi.awid    = WR_ID;
        axi.awaddr  = wr_addr_q;
        axi.awsize  = {1'b0, wr_size_q};
        axi.awvalid = (wr_state_q == WSend) && !aw_done_q;
        axi.wid     = WR_ID;
        axi.wdata   = wr_data_q;
        axi.wstrb   = wr_strb_q;
        axi.wlast   = 1'b1;
        axi.wvalid  = (wr_state_q == WSend) && !w_done_q;
        axi.bready  = (wr_state_q == WResp);

        axi.arlen   = 8'd0;
        axi.arburst = 2'b01;
        axi.arlock  = 2'b00;
        axi.arcache = 4'd0;
        axi.arprot  = 3'd0;
        axi.awlen   = 8'd0;
        axi.awburst = 2'b01;
        axi.awlock  = 2'b00;
        axi.awcache = 4'd0;
        axi.awprot  = 3'd0;
    end

    // Responses' id/resp/last and the instruction port's write fields carry no information here.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: reads, arbitration, writes, ordering and reset abort.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    sram_axi_bridge_if axi ();

    sram_axi_bridge dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .axi               (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic quiet();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2; inst_sram_addr = 0;
        inst_sram_wstrb = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 0;
        data_sram_wstrb = 0; data_sram_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1;
        axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0;
        axi.bvalid = 0;
    endtask

    initial begin
        resetn = 0;
        quiet();
        inst_sram_req = 1;
        #12;
        chk("rst_inst_addr_ok", inst_sram_addr_ok, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_inst_data_ok", inst_sram_data_ok, 0);
        chk("rst_rdata", inst_sram_rdata, 0);
        inst_sram_req = 0;
        #1 resetn = 1;

        // Single instruction read
        go(); inst_sram_req = 1; inst_sram_addr = 32'hBFC00000; axi.arready = 1; settle();
        chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t1_arvalid_c0", axi.arvalid, 0);
        go(); inst_sram_req = 0; settle();
        chk("t1_arvalid_c1", axi.arvalid, 1);
        chk("t1_araddr", axi.araddr, 32'hBFC00000);
        chk("t1_arid", axi.arid, 0);
        chk("t1_arsize", axi.arsize, 2);
        chk("t1_arlen", axi.arlen, 0);
        chk("t1_arburst", axi.arburst, 1);
        go(); axi.rvalid = 1; axi.rdata = 32'h3C1D0001; settle();
        chk("t1_rready", axi.rready, 1);
        chk("t1_arvalid_c2", axi.arvalid, 0);
        chk("t1_data_ok_c2", inst_sram_data_ok, 0);
        go(); axi.rvalid = 0; settle();
        chk("t1_data_ok_c3", inst_sram_data_ok, 1);
        chk("t1_rdata", inst_sram_rdata, 32'h3C1D0001);
        chk("t1_dport_data_ok", data_sram_data_ok, 0);
        go(); settle();
        chk("t1_data_ok_c4", inst_sram_data_ok, 0);

        // Simultaneous instruction and data reads: data wins
        go(); inst_sram_req = 1; inst_sram_addr = 32'hBFC00010;
        data_sram_req = 1; data_sram_addr = 32'h00001000; settle();
        chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_addr_ok_c0", inst_sram_addr_ok, 0);
        go(); data_sram_req = 0; settle();
        chk("t2_arid_data", axi.arid, 1);
        chk("t2_araddr_data", axi.araddr, 32'h00001000);
        chk("t2_inst_addr_ok_c1", inst_sram_addr_ok, 0);
        go(); axi.rvalid = 1; axi.rdata = 32'hA5A50001; settle();
        chk("t2_inst_addr_ok_c2", inst_sram_addr_ok, 0);
        go(); axi.rvalid = 0; settle();
        chk("t2_data_data_ok", data_sram_data_ok, 1);
        chk("t2_data_rdata", data_sram_rdata, 32'hA5A50001);
        chk("t2_inst_addr_ok_resp", inst_sram_addr_ok, 0);
        go(); settle();
        chk("t2_inst_addr_ok_idle", inst_sram_addr_ok, 1);
        go(); inst_sram_req = 0; settle();
        chk("t2_arid_inst", axi.arid, 0);
        chk("t2_araddr_inst", axi.araddr, 32'hBFC00010);
        go(); axi.rvalid = 1; axi.rdata = 32'h0BADF00D; settle();
        go(); axi.rvalid = 0; settle();
        chk("t2_inst_data_ok", inst_sram_data_ok, 1);
        chk("t2_inst_rdata", inst_sram_rdata, 32'h0BADF00D);
        quiet();

        // Data write, W handshake three cycles before AW
        go(); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1FAF0000;
        data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'b0011; axi.wready = 1; settle();
        chk("t3_addr_ok", data_sram_addr_ok, 1);
        go(); data_sram_req = 0; settle();
        chk("t3_awvalid_c1", axi.awvalid, 1);
        chk("t3_wvalid_c1", axi.wvalid, 1);
        chk("t3_wlast", axi.wlast, 1);
        chk("t3_awaddr", axi.awaddr, 32'h1FAF0000);
        chk("t3_wdata", axi.wdata, 32'h12345678);
        chk("t3_wstrb", axi.wstrb, 4'b0011);
        chk("t3_awid", axi.awid, 1);
        chk("t3_awsize", axi.awsize, 2);
        go(); axi.wready = 0; settle();
        chk("t3_wvalid_c2", axi.wvalid, 0);
        chk("t3_awvalid_c2", axi.awvalid, 1);
        chk("t3_bready_c2", axi.bready, 0);
        go(); settle();
        chk("t3_awvalid_c3", axi.awvalid, 1);
        go(); axi.awready = 1; settle();
        chk("t3_awvalid_c4", axi.awvalid, 1);
        go(); axi.awready = 0; axi.bvalid = 1; settle();
        chk("t3_awvalid_c5", axi.awvalid, 0);
        chk("t3_bready_c5", axi.bready, 1);
        chk("t3_data_ok_c5", data_sram_data_ok, 0);
        go(); axi.bvalid = 0; settle();
        chk("t3_data_ok_c6", data_sram_data_ok, 1);
        chk("t3_bready_c6", axi.bready, 0);
        go(); settle();
        chk("t3_data_ok_c7", data_sram_data_ok, 0);

        // Outstanding write blocks a data read to the same address
        go(); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1FAF0004;
        data_sram_wdata = 32'hCAFEBABE; data_sram_wstrb = 4'hF;
        axi.awready = 1; axi.wready = 1; settle();
        chk("t4_wr_addr_ok", data_sram_addr_ok, 1);
        go(); data_sram_wr = 0; settle();
        chk("t4_rd_blocked_send", data_sram_addr_ok, 0);
        go(); axi.bvalid = 1; settle();
        chk("t4_rd_blocked_resp", data_sram_addr_ok, 0);
        chk("t4_no_ar_resp", axi.arvalid, 0);
        go(); axi.bvalid = 0; settle();
        chk("t4_rd_blocked_done", data_sram_addr_ok, 0);
        chk("t4_wr_data_ok", data_sram_data_ok, 1);
        chk("t4_no_ar_done", axi.arvalid, 0);
        go(); axi.arready = 1; settle();
        chk("t4_rd_addr_ok", data_sram_addr_ok, 1);
        go(); data_sram_req = 0; settle();
        chk("t4_arvalid", axi.arvalid, 1);
        chk("t4_arid", axi.arid, 1);
        chk("t4_araddr", axi.araddr, 32'h1FAF0004);
        go(); axi.rvalid = 1; axi.rdata = 32'hCAFEBABE; settle();
        go(); axi.rvalid = 0; settle();
        chk("t4_rd_data_ok", data_sram_data_ok, 1);
        chk("t4_rd_rdata", data_sram_rdata, 32'hCAFEBABE);
        quiet();

        // Instruction read overlapping a data write
        go(); inst_sram_req = 1; inst_sram_addr = 32'hBFC00020;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00002000;
        data_sram_wdata = 32'h55AA55AA; data_sram_wstrb = 4'hF;
        axi.arready = 1; axi.awready = 1; axi.wready = 1; settle();
        chk("t5_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t5_data_addr_ok", data_sram_addr_ok, 1);
        go(); inst_sram_req = 0; data_sram_req = 0; settle();
        chk("t5_arvalid", axi.arvalid, 1);
        chk("t5_awvalid", axi.awvalid, 1);
        chk("t5_wvalid", axi.wvalid, 1);
        go(); axi.rvalid = 1; axi.rdata = 32'h11112222; settle();
        chk("t5_rready", axi.rready, 1);
        chk("t5_bready", axi.bready, 1);
        go(); axi.rvalid = 0; axi.bvalid = 1; settle();
        chk("t5_inst_data_ok", inst_sram_data_ok, 1);
        chk("t5_data_data_ok_early", data_sram_data_ok, 0);
        go(); axi.bvalid = 0; settle();
        chk("t5_data_data_ok", data_sram_data_ok, 1);
        chk("t5_inst_data_ok_gone", inst_sram_data_ok, 0);
        quiet();

        // Reset while waiting for read data
        go(); inst_sram_req = 1; inst_sram_addr = 32'hBFC00100; axi.arready = 1; settle();
        chk("t6_addr_ok", inst_sram_addr_ok, 1);
        go(); inst_sram_req = 0; settle();
        go(); settle();
        chk("t6_rready_before", axi.rready, 1);
        inst_sram_req = 1;
        #1 resetn = 0;
        #1;
        chk("t6_rready_rst", axi.rready, 0);
        chk("t6_addr_ok_rst", inst_sram_addr_ok, 0);
        chk("t6_rdata_rst", inst_sram_rdata, 0);
        inst_sram_req = 0;
        #2 resetn = 1;
        go(); axi.rvalid = 1; axi.rdata = 32'hDEADBEEF; settle();
        chk("t6_rready_after", axi.rready, 0);
        go(); axi.rvalid = 0; settle();
        chk("t6_no_inst_data_ok", inst_sram_data_ok, 0);
        chk("t6_no_data_data_ok", data_sram_data_ok, 0);
        go(); settle();
        chk("t6_no_inst_data_ok2", inst_sram_data_ok, 0);
        chk("t6_rdata_kept", inst_sram_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
